// File: rtl/idli_pkg.sv
// Shared types for the idli core and its SQI memory responder.
package idli_pkg;

  typedef logic [3:0] slice_t;

  typedef enum logic [7:0] {
    SQI_OP_WRITE = 8'h02,
    SQI_OP_READ  = 8'h03
  } sqi_op_t;

  typedef enum logic [2:0] {
    SQI_ST_IDLE,
    SQI_ST_CMD,
    SQI_ST_ADDR,
    SQI_ST_DUMMY,
    SQI_ST_READ,
    SQI_ST_WRITE,
    SQI_ST_IGNORE
  } sqi_mem_state_t;

endpackage

// File: rtl/idli_sqi_mem_ram_m.sv
// Byte-wide storage for the SQI responder: one synchronous write port, one asynchronous read port.
module idli_sqi_mem_ram_m #(
  parameter int unsigned DEPTH = 65536
) (
  input  logic                     i_gck,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [7:0]               i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [7:0]               o_rdata
);

  logic [7:0] mem [DEPTH];

  // Contents deliberately survive reset.
  always_ff @(posedge i_gck) begin
    if (i_we) mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/idli_sqi_mem_m.sv
// SQI SRAM responder: decodes READ/WRITE, a 24-bit address, then streams nibbles
// to or from the byte store. sck is oversampled on gck.
module idli_sqi_mem_m
  import idli_pkg::*;
#(
  parameter int unsigned DEPTH = 65536
) (
  input  logic   i_mem_gck,
  input  logic   i_mem_rst_n,
  input  logic   i_mem_sck,
  input  logic   i_mem_cs,
  input  slice_t i_mem_sio,
  output slice_t o_mem_sio,
  output logic   o_mem_sio_en
);

  localparam int unsigned AW = $clog2(DEPTH);

  sqi_mem_state_t state_q, state_d;
  logic           sck_q;
  logic [2:0]     ctr_q, ctr_d;
  logic [23:0]    addr_q, addr_d;
  logic [7:0]     shift_q, shift_d;
  logic           is_read_q, is_read_d;
  slice_t         sio_q, sio_d;
  logic           en_q, en_d;

  logic          rise_c, fall_c, we_c;
  logic [7:0]    byte_c, rdata_c;
  logic [AW-1:0] raddr_c;

  assign rise_c = i_mem_sck & ~sck_q;
  assign fall_c = ~i_mem_sck & sck_q;
  // Held high nibble plus the nibble arriving now completes an opcode or data byte.
  assign byte_c = {shift_q[7:4], i_mem_sio};

  always_ff @(posedge i_mem_gck or negedge i_mem_rst_n) begin
    if (!i_mem_rst_n) begin
      state_q   <= SQI_ST_IDLE;
      sck_q     <= 1'b0;
      ctr_q     <= 3'd0;
      addr_q    <= 24'd0;
      shift_q   <= 8'd0;
      is_read_q <= 1'b0;
      sio_q     <= 4'd0;
      en_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      sck_q     <= i_mem_sck;
      ctr_q     <= ctr_d;
      addr_q    <= addr_d;
      shift_q   <= shift_d;
      is_read_q <= is_read_d;
      sio_q     <= sio_d;
      en_q      <= en_d;
    end
  end

  // Next state; deselect overrides everything, including a coincident rise.
  always_comb begin
    state_d = state_q;
    if (!i_mem_cs) begin
      state_d = SQI_ST_IDLE;
    end else begin
      case (state_q)
        SQI_ST_IDLE:  state_d = SQI_ST_CMD;
        SQI_ST_CMD:   if (rise_c && ctr_q[0])
                        state_d = (byte_c == SQI_OP_READ || byte_c == SQI_OP_WRITE)
                                  ? SQI_ST_ADDR : SQI_ST_IGNORE;
        SQI_ST_ADDR:  if (rise_c && ctr_q == 3'd5)
                        state_d = is_read_q ? SQI_ST_DUMMY : SQI_ST_WRITE;
        SQI_ST_DUMMY: if (rise_c && ctr_q[0]) state_d = SQI_ST_READ;
        default:      state_d = state_q;
      endcase
    end
  end

  // Datapath and outputs.
  always_comb begin
    ctr_d     = ctr_q;
    addr_d    = addr_q;
    shift_d   = shift_q;
    is_read_d = is_read_q;
    sio_d     = sio_q;
    en_d      = en_q;
    we_c      = 1'b0;
    raddr_c   = addr_q[AW-1:0];
    if (!i_mem_cs) begin
      ctr_d = 3'd0;
      en_d  = 1'b0;
    end else begin
      case (state_q)
        SQI_ST_IDLE: begin
          ctr_d = 3'd0;
          en_d  = 1'b0;
        end
        SQI_ST_CMD: if (rise_c) begin
          shift_d[7:4] = i_mem_sio;
          ctr_d        = ctr_q + 3'd1;
          if (ctr_q[0]) begin
            ctr_d     = 3'd0;
            is_read_d = (byte_c == SQI_OP_READ);
          end
        end
        SQI_ST_ADDR: if (rise_c) begin
          addr_d = {addr_q[19:0], i_mem_sio};
          ctr_d  = (ctr_q == 3'd5) ? 3'd0 : ctr_q + 3'd1;
        end
        SQI_ST_DUMMY: if (rise_c) begin
          ctr_d = ctr_q + 3'd1;
          if (ctr_q[0]) begin
            ctr_d   = 3'd0;
            shift_d = rdata_c;
          end
        end
        // Low nibble out: step the address and prefetch through the incremented read address.
        SQI_ST_READ: if (fall_c) begin
          en_d  = 1'b1;
          sio_d = ctr_q[0] ? shift_q[3:0] : shift_q[7:4];
          ctr_d = {2'b00, ~ctr_q[0]};
          if (ctr_q[0]) begin
            addr_d  = addr_q + 24'd1;
            raddr_c = AW'(addr_q + 24'd1);
            shift_d = rdata_c;
          end
        end
        SQI_ST_WRITE: if (rise_c) begin
          if (!ctr_q[0]) begin
            shift_d[7:4] = i_mem_sio;
            ctr_d        = 3'd1;
          end else begin
            we_c   = 1'b1;
            addr_d = addr_q + 24'd1;
            ctr_d  = 3'd0;
          end
        end
        default: ctr_d = ctr_q;
      endcase
    end
  end

  idli_sqi_mem_ram_m #(.DEPTH(DEPTH)) u_ram (
    .i_gck   (i_mem_gck),
    .i_we    (we_c),
    .i_waddr (addr_q[AW-1:0]),
    .i_wdata (byte_c),
    .i_raddr (raddr_c),
    .o_rdata (rdata_c)
  );

  assign o_mem_sio    = sio_q;
  assign o_mem_sio_en = en_q;

endmodule

// File: tb/tb_idli_sqi_mem_m.sv
// Directed bench for the SQI memory responder with a byte model and a nibble scoreboard.
module tb_idli_sqi_mem_m;

  localparam int unsigned DEPTH = 65536;
  localparam int MASK = DEPTH - 1;
  localparam int M_IDLE = 0;
  localparam int M_DATA = 1;
  localparam int M_NONE = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sck = 1'b0;
  logic       cs = 1'b0;
  logic [3:0] sio_in = 4'd0;
  logic [3:0] sio_out;
  logic       sio_en;

  int checks = 0;
  int errors = 0;
  int hc = 2;
  int lc = 2;
  logic [7:0] mdl [int];
  logic [3:0] sb [$];

  idli_sqi_mem_m #(.DEPTH(DEPTH)) dut (
    .i_mem_gck    (clk),
    .i_mem_rst_n  (rst_n),
    .i_mem_sck    (sck),
    .i_mem_cs     (cs),
    .i_mem_sio    (sio_in),
    .o_mem_sio    (sio_out),
    .o_mem_sio_en (sio_en)
  );

  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One sck period starting and ending at a gck negedge; checks follow the fall.
  task automatic nib(input logic [3:0] d, input int mode);
    logic [3:0] e;
    sio_in = d;
    sck    = 1'b1;
    repeat (hc) @(negedge clk);
    sck = 1'b0;
    @(negedge clk);
    if (mode == M_IDLE) begin
      chk("en_idle", 8'(sio_en), 8'd0);
    end else if (mode == M_DATA) begin
      chk("sb_level", 8'(sb.size() > 0), 8'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("rd_nib", 8'(sio_out), 8'(e));
        chk("rd_en", 8'(sio_en), 8'd1);
      end
    end
    repeat (lc - 1) @(negedge clk);
  endtask

  task automatic cs_on();
    cs = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic cs_off();
    cs = 1'b0;
    @(negedge clk);
    chk("en_after_cs", 8'(sio_en), 8'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic hdr(input logic [7:0] op, input logic [23:0] a);
    nib(op[7:4], M_IDLE);
    nib(op[3:0], M_IDLE);
    for (int i = 5; i >= 0; i--) nib(a[i*4 +: 4], M_IDLE);
  endtask

  task automatic wr2(input logic [23:0] a, input logic [7:0] b0, input logic [7:0] b1);
    cs_on();
    hdr(8'h02, a);
    nib(b0[7:4], M_IDLE); nib(b0[3:0], M_IDLE);
    nib(b1[7:4], M_IDLE); nib(b1[3:0], M_IDLE);
    cs_off();
    mdl[int'(a) & MASK]       = b0;
    mdl[(int'(a) + 1) & MASK] = b1;
  endtask

  task automatic rd(input logic [23:0] a, input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = mdl[(int'(a) + i) & MASK];
      sb.push_back(b[7:4]);
      sb.push_back(b[3:0]);
    end
    cs_on();
    hdr(8'h03, a);
    nib(4'h0, M_IDLE);
    nib(4'h0, M_DATA);
    for (int i = 1; i < 2 * n; i++) nib(4'h0, M_DATA);
    cs_off();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_sio", 8'(sio_out), 8'd0);
    chk("rst_en", 8'(sio_en), 8'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic write then read-back.
    wr2(24'h000010, 8'hA5, 8'h3C);
    rd(24'h000010, 2);

    // Address wrap at the top of storage.
    wr2(24'(DEPTH - 1), 8'h11, 8'h22);
    rd(24'(DEPTH - 1), 2);
    rd(24'h000000, 1);

    // Unknown opcode: rest of the frame must not write or drive.
    cs_on();
    nib(4'h0, M_IDLE); nib(4'h5, M_IDLE);
    for (int i = 0; i < 6; i++) nib(4'h0, M_IDLE);
    nib(4'h1, M_IDLE); nib(4'h0, M_IDLE); nib(4'hF, M_IDLE); nib(4'hF, M_IDLE);
    cs_off();
    rd(24'h000010, 2);

    // Deselect mid-byte keeps the completed byte only.
    wr2(24'h000020, 8'h00, 8'h5A);
    cs_on();
    hdr(8'h02, 24'h000020);
    nib(4'h7, M_IDLE); nib(4'h7, M_IDLE); nib(4'h9, M_IDLE);
    cs_off();
    mdl[32'h20] = 8'h77;
    rd(24'h000020, 2);

    // Reset during the read data phase.
    sb.push_back(4'hA); sb.push_back(4'h5); sb.push_back(4'h3); sb.push_back(4'hC);
    cs_on();
    hdr(8'h03, 24'h000010);
    nib(4'h0, M_IDLE);
    nib(4'h0, M_DATA);
    nib(4'h0, M_DATA);
    rst_n = 1'b0;
    cs    = 1'b0;
    sck   = 1'b0;
    #1;
    chk("rst_mid_en", 8'(sio_en), 8'd0);
    chk("rst_mid_sio", 8'(sio_out), 8'd0);
    sb.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    rd(24'h000010, 2);

    // Fast and slow sck give the same data and one-gck output latency.
    hc = 1; lc = 1;
    wr2(24'h000100, 8'hC3, 8'h96);
    rd(24'h000100, 2);
    rd(24'h000010, 2);
    hc = 4; lc = 4;
    rd(24'h000100, 2);
    rd(24'h000010, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
